// File: rtl/twos_comp_serial.sv
// ============================================================================
// Module   : twos_comp_serial
// Purpose  : Bit-serial two's-complement engine. A WIDTH-bit operand is
//            loaded on start and processed LSB first, one bit per clock,
//            using copy-until-first-one. The result is either the negated
//            operand (mode=0) or its absolute value (mode=1), returned with
//            a start/busy/done handshake. Arithmetic is modulo 2^WIDTH.
//
// Parameters:
//   WIDTH    operand/result width in bits (2..64), default 12
//   CNT_W    bit-counter width, derived as $clog2(WIDTH+1)
//
// Ports:
//   t_clk     in   1      system clock, rising edge
//   t_rst     in   1      asynchronous active-high reset
//   start     in   1      begin a conversion (honoured in IDLE only)
//   mode      in   1      0 = negate, 1 = absolute value (sampled with start)
//   x         in   WIDTH  operand (sampled with start)
//   o         out  WIDTH  registered result, held until the next result
//   busy      out  1      high while bits are being processed
//   done      out  1      one-cycle pulse, result valid on o
//   so_bit    out  1      serial result bit of the current SHIFT cycle
//   so_valid  out  1      so_bit is meaningful (SHIFT state)
//   ovf       out  1      only with TWOS_COMP_OVF_DETECT_EN defined: pulses
//                         with done when a negation of the most-negative
//                         operand wrapped back to itself
//
// Build option:
//   TWOS_COMP_OVF_DETECT_EN  define to add the ovf output and its logic
//
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module twos_comp_serial #(
  parameter int WIDTH = 12,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             t_clk,
  input  logic             t_rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] o,
  output logic             busy,
  output logic             done,
  output logic             so_bit,
  output logic             so_valid
`ifdef TWOS_COMP_OVF_DETECT_EN
  ,
  output logic             ovf
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Counter value held while the final bit is being processed; the edge that
  // consumes this bit is the one that completes the conversion.
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

`ifdef TWOS_COMP_OVF_DETECT_EN
  // Most-negative value: 1 followed by WIDTH-1 zeros.
  localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  // r_sr doubles as the operand shifter and the result accumulator: each
  // cycle the operand LSB is consumed from the bottom and the result bit is
  // pushed in at the top, so after WIDTH shifts it holds the full result
  // with bit 0 in position 0.
  logic [WIDTH-1:0] r_sr;
  logic             r_neg_en;    // 1 = complement after the first one
  logic             r_seen_one;  // a 1 has been consumed from the operand
  logic [CNT_W-1:0] r_cnt;       // bits processed so far
  logic [WIDTH-1:0] r_o;

`ifdef TWOS_COMP_OVF_DETECT_EN
  logic             r_ovf;
`endif

  // --------------------------------------------------------------------------
  // Serial bit logic
  // --------------------------------------------------------------------------
  logic             w_bit;       // operand bit under processing
  logic             w_res_bit;   // resulting bit
  logic             w_last;      // final bit of the operand this cycle
  logic [WIDTH-1:0] w_sr_nxt;    // shifter after this cycle

  // Copy-until-first-one: bits up to and including the first 1 pass through
  // unchanged, every later bit is inverted. With neg_en low the operand is
  // passed through as is (absolute value of a non-negative number).
  assign w_bit     = r_sr[0];
  assign w_res_bit = (r_neg_en & r_seen_one) ? ~w_bit : w_bit;
  assign w_last    = (r_cnt == c_last);
  assign w_sr_nxt  = {w_res_bit, r_sr[WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge t_clk or posedge t_rst) begin
    if (t_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // --------------------------------------------------------------------------
  // busy, done and so_valid follow directly from the registered state, so
  // they are glitch-free and drop to zero the moment reset asserts. so_bit
  // is gated so it never shows a stale value outside SHIFT.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    so_bit      = 1'b0;
    so_valid    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy     = 1'b1;
        so_valid = 1'b1;
        so_bit   = w_res_bit;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge t_clk or posedge t_rst) begin
    if (t_rst) begin
      r_sr       <= '0;
      r_neg_en   <= 1'b0;
      r_seen_one <= 1'b0;
      r_cnt      <= '0;
      r_o        <= '0;
`ifdef TWOS_COMP_OVF_DETECT_EN
      r_ovf      <= 1'b0;
`endif
    end else begin
`ifdef TWOS_COMP_OVF_DETECT_EN
      // Pulse only; re-asserted below on the completing edge when needed.
      r_ovf <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sr       <= x;
            // Negation always complements; absolute value only when the
            // operand is negative.
            r_neg_en   <= ~mode | x[WIDTH-1];
            r_seen_one <= 1'b0;
            r_cnt      <= '0;
          end
        end

        ST_SHIFT: begin
          r_sr       <= w_sr_nxt;
          r_seen_one <= r_seen_one | w_bit;
          r_cnt      <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_o <= w_sr_nxt;
`ifdef TWOS_COMP_OVF_DETECT_EN
            // With neg_en set the operation is a true negation, which is a
            // bijection; the only operand that maps to c_min is c_min
            // itself, so checking the result identifies the wrap case.
            r_ovf <= r_neg_en & (w_sr_nxt == c_min);
`endif
          end
        end

        default: begin
          // ST_DONE: nothing to update; o keeps the fresh result.
        end
      endcase
    end
  end

  assign o = r_o;

`ifdef TWOS_COMP_OVF_DETECT_EN
  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_twos_comp_serial.sv
`default_nettype none

module tb_twos_comp_serial;

  localparam int W = 12;

  logic         t_clk;
  logic         t_rst;
  logic         start;
  logic         mode;
  logic [W-1:0] x;
  wire  [W-1:0] o;
  wire          busy;
  wire          done;
  wire          so_bit;
  wire          so_valid;
`ifdef TWOS_COMP_OVF_DETECT_EN
  wire          ovf;
`endif

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] last_o;

  twos_comp_serial #(.WIDTH(W)) dut (
    .t_clk    (t_clk),
    .t_rst    (t_rst),
    .start    (start),
    .mode     (mode),
    .x        (x),
    .o        (o),
    .busy     (busy),
    .done     (done),
    .so_bit   (so_bit),
    .so_valid (so_valid)
`ifdef TWOS_COMP_OVF_DETECT_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial begin
    t_clk = 1'b0;
    forever #5 t_clk = ~t_clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic on the whole operand.
  function automatic logic [W-1:0] model(input logic m, input logic [W-1:0] v);
    logic [W-1:0] neg;
    neg = W'(0) - v;
    if (!m || v[W-1]) return neg;
    return v;
  endfunction

  function automatic logic model_ovf(input logic m, input logic [W-1:0] v);
    logic [W-1:0] mn;
    mn = '0;
    mn[W-1] = 1'b1;
    return (!m || v[W-1]) && (v == mn);
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Present an operand with start for one edge, then scramble x/mode to
  // show they are not looked at after sampling.
  task automatic launch(input logic m, input logic [W-1:0] v);
    start = 1'b1;
    mode  = m;
    x     = v;
    @(posedge t_clk); #1;
    start = 1'b0;
    x     = rand_w();
    mode  = 1'($urandom());
  endtask

  // Walk the WIDTH SHIFT cycles, then check the DONE cycle. inject_at >= 0
  // pulses a competing start during that SHIFT cycle.
  task automatic finish(input logic m, input logic [W-1:0] v, input int inject_at);
    logic [W-1:0] e;
    e = model(m, v);
    for (int k = 0; k < W; k++) begin
      check("busy_shift", busy, 1);
      check("done_early", done, 0);
      check("so_valid", so_valid, 1);
      check("so_bit", so_bit, e[k]);
      check("o_hold", o, last_o);
      if (k == inject_at) begin
        start = 1'b1;
        mode  = 1'b1;
        x     = W'(1);
      end
      @(posedge t_clk); #1;
      start = 1'b0;
    end
    check("done", done, 1);
    check("busy_off", busy, 0);
    check("so_valid_off", so_valid, 0);
    check("so_bit_off", so_bit, 0);
    check("result", o, e);
`ifdef TWOS_COMP_OVF_DETECT_EN
    check("ovf", ovf, model_ovf(m, v));
`endif
    last_o = e;
  endtask

  task automatic idle_step();
    @(posedge t_clk); #1;
    check("done_clear", done, 0);
    check("busy_idle", busy, 0);
    check("o_idle", o, last_o);
`ifdef TWOS_COMP_OVF_DETECT_EN
    check("ovf_clear", ovf, 0);
`endif
  endtask

  task automatic run_op(input logic m, input logic [W-1:0] v);
    launch(m, v);
    finish(m, v, -1);
    idle_step();
  endtask

  initial begin
    logic         m;
    logic [W-1:0] v;
    logic [W-1:0] mn;

    t_rst  = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    x      = '0;
    last_o = '0;
    mn     = '0;
    mn[W-1] = 1'b1;

    repeat (2) @(posedge t_clk);
    #1;
    check("rst_o", o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_so_valid", so_valid, 0);
    check("rst_so_bit", so_bit, 0);
`ifdef TWOS_COMP_OVF_DETECT_EN
    check("rst_ovf", ovf, 0);
`endif
    @(negedge t_clk);
    t_rst = 1'b0;

    // Directed cases
    run_op(1'b0, W'(12'h005));
    run_op(1'b0, W'(12'h000));
    run_op(1'b1, W'(12'hFFB));
    run_op(1'b1, W'(12'h123));
    run_op(1'b0, mn);
    run_op(1'b0, mn | W'(1));
    run_op(1'b1, mn);
    run_op(1'b1, W'(0));

    // Start during SHIFT and during DONE is ignored; the next edge accepts.
    launch(1'b0, W'(12'h00A));
    finish(1'b0, W'(12'h00A), 5);
    start = 1'b1;
    mode  = 1'b0;
    x     = W'(12'h003);
    @(posedge t_clk); #1;
    check("done_start_ignored", busy, 0);
    check("done_start_done", done, 0);
    @(posedge t_clk); #1;
    start = 1'b0;
    x     = rand_w();
    check("idle_start_taken", busy, 1);
    finish(1'b0, W'(12'h003), -1);
    idle_step();

    // Asynchronous reset in the middle of a conversion.
    launch(1'b0, W'(12'h00A));
    repeat (6) begin
      @(posedge t_clk); #1;
    end
    #3;
    t_rst = 1'b1;
    #1;
    check("arst_o", o, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_so_valid", so_valid, 0);
    check("arst_so_bit", so_bit, 0);
    last_o = '0;
    @(posedge t_clk); #1;
    check("arst_hold_busy", busy, 0);
    @(negedge t_clk);
    t_rst = 1'b0;
    repeat (W + 2) begin
      @(posedge t_clk); #1;
      check("arst_no_done", done, 0);
    end
    run_op(1'b0, W'(12'h003));

    // Randomized traffic, biased toward the corner operands.
    for (int i = 0; i < 60; i++) begin
      m = 1'($urandom());
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = mn;
        2:       v = ~mn;
        3:       v = '1;
        default: v = rand_w();
      endcase
      run_op(m, v);
      repeat ($urandom_range(0, 2)) idle_step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
